// File: rtl/sysid_checker_pkg.sv
// -----------------------------------------------------------------------------
// sysid_checker_pkg
// Shared types and constants for the SysID checker: the FSM state encoding,
// the Avalon-MM word-select values and the default expected SysID contents.
// -----------------------------------------------------------------------------
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID_REQ,
        ST_ID_WAIT,
        ST_TS_REQ,
        ST_TS_WAIT,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // SysID word select on m_address
    localparam logic ID_WORD = 1'b0;
    localparam logic TS_WORD = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1617773073;

    // A check is in progress in every state except the two resting ones.
    function automatic logic is_busy_state(input state_t s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage

// File: rtl/sysid_checker_timer.sv
// -----------------------------------------------------------------------------
// sysid_checker_timer
// Per-state wait counter. Reloads to zero on clear, counts while enabled and
// flags the last permitted cycle of the current state.
//
// Ports
//   clock    : sole clock, rising edge
//   reset    : synchronous, active-high
//   clear    : load zero (state entry); has priority over enable
//   enable   : count this cycle
//   expired  : high during the TIMEOUT_CYCLES-th enabled cycle since clear
// -----------------------------------------------------------------------------
module sysid_checker_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    // NOTE: registers are written with <= so every flop samples the
    // pre-edge values of its inputs, independent of process ordering.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    // The owning state leaves on this cycle, so the counter never wraps.
    assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/sysid_checker.sv
// -----------------------------------------------------------------------------
// sysid_checker
// Reads the two SysID words over Avalon-MM (ID at word 0, timestamp at word 1),
// compares them with the expected values and reports pass / timeout. Each
// request and wait phase is bounded by TIMEOUT_CYCLES; a missing read response
// is re-requested up to MAX_RETRIES times per word. All outputs are registered.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start                 : one-cycle request to run a check (ignored when busy)
//   m_address, m_read     : Avalon-MM master word select and read strobe
//   m_waitrequest         : slave stall
//   m_readdata[31:0]      : read data, qualified by m_readdatavalid
//   busy, done            : check running / check finished (level)
//   pass, timeout_err     : result flags, held in DONE
//   id_value, ts_value    : last captured words
// -----------------------------------------------------------------------------
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    state_t             state, state_next;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               after_reset;
    logic               timer_clear, timer_enable, timer_expired;
    logic               pass_d, timeout_d;
    logic [31:0]        id_d, ts_d;

    sysid_checker_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        retry_d    = retry_q;
        pass_d     = pass;
        timeout_d  = timeout_err;
        id_d       = id_value;
        ts_d       = ts_value;

        case (state)
            // Read data arriving here is never captured, so start always wins.
            ST_IDLE, ST_DONE: begin
                if (start || (AUTO_START && after_reset)) begin
                    state_next = ST_ID_REQ;
                    retry_d    = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            // A stalled request is not retried: the slave is not accepting.
            ST_ID_REQ, ST_TS_REQ: begin
                if (!m_waitrequest) begin
                    state_next = (state == ST_ID_REQ) ? ST_ID_WAIT : ST_TS_WAIT;
                end else if (timer_expired) begin
                    state_next = ST_DONE;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b1;
                end
            end
            ST_ID_WAIT, ST_TS_WAIT: begin
                if (m_readdatavalid) begin
                    if (state == ST_ID_WAIT) begin
                        id_d       = m_readdata;
                        retry_d    = '0;
                        state_next = ST_TS_REQ;
                    end else begin
                        ts_d       = m_readdata;
                        state_next = ST_COMPARE;
                    end
                end else if (timer_expired) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d    = retry_q + RETRY_W'(1);
                        state_next = (state == ST_ID_WAIT) ? ST_ID_REQ : ST_TS_REQ;
                    end else begin
                        state_next = ST_DONE;
                        pass_d     = 1'b0;
                        timeout_d  = 1'b1;
                    end
                end
            end
            ST_COMPARE: begin
                pass_d     = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        timer_clear  = (state_next != state);
        timer_enable = (state == ST_ID_REQ) || (state == ST_ID_WAIT) ||
                       (state == ST_TS_REQ) || (state == ST_TS_WAIT);
    end

    // Bus and status outputs are decoded from the next state and registered,
    // so they change on the same edge as the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            after_reset <= 1'b1;
            retry_q     <= '0;
            m_read      <= 1'b0;
            m_address   <= ID_WORD;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state       <= state_next;
            after_reset <= 1'b0;
            retry_q     <= retry_d;
            m_read      <= (state_next == ST_ID_REQ) || (state_next == ST_TS_REQ);
            m_address   <= ((state_next == ST_TS_REQ) || (state_next == ST_TS_WAIT))
                           ? TS_WORD : ID_WORD;
            busy        <= is_busy_state(state_next);
            done        <= (state_next == ST_DONE);
            pass        <= pass_d;
            timeout_err <= timeout_d;
            id_value    <= id_d;
            ts_value    <= ts_d;
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_sysid_checker
// Directed bench for sysid_checker. A behavioural Avalon-MM slave answers the
// checker's reads with configurable stalls, data and dropped responses. The
// DUT runs with TIMEOUT_CYCLES=8, MAX_RETRIES=2 and AUTO_START=1. Inputs are
// driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1617773073;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_readdata = '0;
    logic        m_readdatavalid = 1'b0;
    logic        busy, done, pass, timeout_err;
    logic [31:0] id_value, ts_value;

    int n_checks = 0;
    int n_fail   = 0;

    // slave configuration and state
    int          stall_cycles = 0;
    bit          stuck = 1'b0;
    bit          drop_ts = 1'b0;
    logic [31:0] id_data = 32'd0;
    logic [31:0] ts_data = TS_GOOD;
    int          stall_cnt = 0;
    bit          accept_pending = 1'b0;
    logic        accept_addr = 1'b0;
    int          id_reads = 0;
    int          ts_reads = 0;
    bit          inject = 1'b0;
    logic [31:0] inject_data = '0;

    always #5 clock = ~clock;

    sysid_checker #(
        .TIMEOUT_CYCLES (8),
        .MAX_RETRIES    (2),
        .AUTO_START     (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout_err     (timeout_err),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    // Slave: waitrequest for the coming edge is decided on the falling edge;
    // a read accepted at an edge is answered during the following cycle.
    always @(negedge clock) begin
        m_readdatavalid = 1'b0;
        if (inject) begin
            m_readdatavalid = 1'b1;
            m_readdata      = inject_data;
            inject          = 1'b0;
        end else if (accept_pending) begin
            accept_pending = 1'b0;
            if (!(accept_addr && drop_ts)) begin
                m_readdatavalid = 1'b1;
                m_readdata      = accept_addr ? ts_data : id_data;
            end
        end
        if (m_read === 1'b1) begin
            if (stuck || (stall_cnt < stall_cycles)) begin
                m_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                m_waitrequest  = 1'b0;
                stall_cnt      = 0;
                accept_pending = 1'b1;
                accept_addr    = m_address;
                if (m_address) ts_reads++;
                else           id_reads++;
            end
        end else begin
            m_waitrequest = 1'b0;
            stall_cnt     = 0;
        end
    end

    // Start pulse sampled at edge N; returns at the falling edge after N.
    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [69:0] obs;
        repeat (3) @(negedge clock);
        obs = {m_read, m_address, busy, done, pass, timeout_err, id_value, ts_value};
        n_checks++;
        if (obs !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected 0", obs);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({busy, m_read, m_address} !== 3'b110) begin
            n_fail++;
            $display("FAIL auto_start: busy/m_read/m_address got %b expected 110",
                     {busy, m_read, m_address});
        end
        repeat (4) @(negedge clock);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_run_early_done: done got %b expected 0", done);
        end
        @(negedge clock);
        n_checks++;
        if ({done, pass, timeout_err} !== 3'b110) begin
            n_fail++;
            $display("FAIL auto_run_result: done/pass/timeout got %b expected 110",
                     {done, pass, timeout_err});
        end
    endtask

    task automatic test_basic_pass();
        pulse_start();
        n_checks++;
        if ({busy, done, pass} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_start: busy/done/pass got %b expected 100", {busy, done, pass});
        end
        repeat (4) @(negedge clock);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_early: done got %b expected 0", done);
        end
        @(negedge clock);
        n_checks++;
        if ({done, busy, pass, timeout_err} !== 4'b1010) begin
            n_fail++;
            $display("FAIL basic_result: done/busy/pass/timeout got %b expected 1010",
                     {done, busy, pass, timeout_err});
        end
        n_checks++;
        if ({id_value, ts_value} !== {32'd0, TS_GOOD}) begin
            n_fail++;
            $display("FAIL basic_values: got %h/%h expected %h/%h", id_value, ts_value, 32'd0, TS_GOOD);
        end
    endtask

    task automatic test_id_mismatch();
        id_data = 32'h0000_0005;
        pulse_start();
        repeat (5) @(negedge clock);
        n_checks++;
        if ({done, pass, timeout_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL mismatch_result: done/pass/timeout got %b expected 100",
                     {done, pass, timeout_err});
        end
        n_checks++;
        if (id_value !== 32'h0000_0005) begin
            n_fail++;
            $display("FAIL mismatch_id_value: got %h expected 00000005", id_value);
        end
        id_data = 32'd0;
    endtask

    task automatic test_wait_states();
        int rd_id = 0;
        int rd_ts = 0;
        bit early = 1'b0;
        stall_cycles = 3;
        pulse_start();
        for (int c = 0; c < 11; c++) begin
            if (m_read === 1'b1) begin
                if (m_address) rd_ts++;
                else           rd_id++;
            end
            if (done === 1'b1) early = 1'b1;
            @(negedge clock);
        end
        n_checks++;
        if ({rd_id, rd_ts} !== {32'd4, 32'd4}) begin
            n_fail++;
            $display("FAIL stall_read_cycles: id/ts read cycles got %0d/%0d expected 4/4", rd_id, rd_ts);
        end
        n_checks++;
        if ({early, done, pass} !== 3'b011) begin
            n_fail++;
            $display("FAIL stall_latency: early/done/pass got %b expected 011", {early, done, pass});
        end
        stall_cycles = 0;
    endtask

    task automatic test_retry_timeout();
        int c;
        drop_ts  = 1'b1;
        ts_reads = 0;
        pulse_start();
        for (c = 0; c < 200 && done !== 1'b1; c++) @(negedge clock);
        n_checks++;
        if (c != 29) begin
            n_fail++;
            $display("FAIL retry_latency: done after %0d cycles expected 29", c);
        end
        n_checks++;
        if ({done, timeout_err, pass} !== 3'b110) begin
            n_fail++;
            $display("FAIL retry_result: done/timeout/pass got %b expected 110",
                     {done, timeout_err, pass});
        end
        n_checks++;
        if (ts_reads != 3) begin
            n_fail++;
            $display("FAIL retry_ts_reads: got %0d expected 3", ts_reads);
        end
        drop_ts = 1'b0;
        pulse_start();
        n_checks++;
        if ({busy, done, timeout_err, pass} !== 4'b1000) begin
            n_fail++;
            $display("FAIL restart_clears: busy/done/timeout/pass got %b expected 1000",
                     {busy, done, timeout_err, pass});
        end
        repeat (5) @(negedge clock);
        n_checks++;
        if ({done, pass, timeout_err} !== 3'b110) begin
            n_fail++;
            $display("FAIL restart_result: done/pass/timeout got %b expected 110",
                     {done, pass, timeout_err});
        end
    endtask

    task automatic test_req_timeout();
        int c;
        int n_rd = 0;
        stuck = 1'b1;
        pulse_start();
        for (c = 0; c < 50 && done !== 1'b1; c++) begin
            if (m_read === 1'b1) n_rd++;
            @(negedge clock);
        end
        n_checks++;
        if ({c, n_rd} !== {32'd8, 32'd8}) begin
            n_fail++;
            $display("FAIL req_timeout_cycles: done after %0d, m_read cycles %0d, expected 8/8", c, n_rd);
        end
        n_checks++;
        if ({done, timeout_err, pass, m_read} !== 4'b1100) begin
            n_fail++;
            $display("FAIL req_timeout_result: done/timeout/pass/m_read got %b expected 1100",
                     {done, timeout_err, pass, m_read});
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [69:0] obs;
        id_data = 32'h0000_0005;
        pulse_start();
        repeat (3) @(negedge clock);
        n_checks++;
        if ({busy, m_read, m_address} !== 3'b101) begin
            n_fail++;
            $display("FAIL mid_ts_wait: busy/m_read/m_address got %b expected 101",
                     {busy, m_read, m_address});
        end
        reset = 1'b1;
        @(negedge clock);
        obs = {m_read, m_address, busy, done, pass, timeout_err, id_value, ts_value};
        n_checks++;
        if (obs !== 70'd0) begin
            n_fail++;
            $display("FAIL mid_reset_values: got %h expected 0", obs);
        end
        id_data = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_auto_busy: busy got %b expected 1", busy);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_early: done got %b expected 0", done);
        end
        @(negedge clock);
        n_checks++;
        if ({done, pass, timeout_err} !== 3'b110) begin
            n_fail++;
            $display("FAIL busy_start_ignored: done/pass/timeout got %b expected 110",
                     {done, pass, timeout_err});
        end
        pulse_start();
        repeat (5) @(negedge clock);
        n_checks++;
        if ({done, pass, id_value} !== {2'b11, 32'd0}) begin
            n_fail++;
            $display("FAIL mid_clean_run: done/pass got %b id %h expected 11/00000000",
                     {done, pass}, id_value);
        end
    endtask

    task automatic test_start_vs_rdv();
        @(posedge clock);
        #1;
        inject_data = 32'hDEAD_BEEF;
        inject      = 1'b1;
        start       = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({busy, id_value} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL start_wins: busy %b id %h expected 1/00000000", busy, id_value);
        end
        repeat (5) @(negedge clock);
        n_checks++;
        if ({done, pass} !== 2'b11) begin
            n_fail++;
            $display("FAIL start_wins_result: done/pass got %b expected 11", {done, pass});
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_id_mismatch();
        test_wait_states();
        test_retry_timeout();
        test_req_timeout();
        test_reset_mid();
        test_start_vs_rdv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
